// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/sub/logic/rotate with persistent carry, plus an
// iterative shift-add multiply that holds busy for WIDTH cycles.
module alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] out,
  output logic             c,
  output logic             z,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpAdc = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;
  localparam logic [2:0] OpRlc = 3'b111;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplr;
  logic [CntW-1:0]    cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_c;
  logic [2*WIDTH-1:0] acc_nxt;

  // Single-cycle datapath; MUL falls through to default and is handled by the FSM.
  always_comb begin
    sum     = '0;
    alu_out = out;
    alu_c   = c;
    unique case (op)
      OpAdd: begin
        sum     = {1'b0, ain} + {1'b0, bin};
        alu_out = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OpAdc: begin
        sum     = {1'b0, ain} + {1'b0, bin} + {{WIDTH{1'b0}}, c};
        alu_out = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OpSub: begin
        // Top bit of the widened difference is the borrow (ain < bin).
        sum     = {1'b0, ain} - {1'b0, bin};
        alu_out = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OpAnd: alu_out = ain & bin;
      OpOr:  alu_out = ain | bin;
      OpXor: alu_out = ain ^ bin;
      OpRlc: begin
        alu_out = {ain[WIDTH-2:0], c};
        alu_c   = ain[WIDTH-1];
      end
      default: ;
    endcase
  end

  assign acc_nxt = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
      out   <= '0;
      c     <= 1'b0;
      z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (op == OpMul) begin
              mcand <= {{WIDTH{1'b0}}, ain};
              mplr  <= bin;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= StMul;
            end else begin
              out  <= alu_out;
              c    <= alu_c;
              z    <= (alu_out == '0);
              done <= 1'b1;
            end
          end
        end
        StMul: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CntLast) begin
            out   <= acc_nxt[WIDTH-1:0];
            c     <= |acc_nxt[2*WIDTH-1:WIDTH];
            z     <= (acc_nxt[WIDTH-1:0] == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4: carry chains, borrow, rotate, multiply timing,
// start-while-busy, back-to-back after MUL and asynchronous reset mid-multiply.
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [W-1:0] out;
  logic         c;
  logic         z;
  logic         busy;
  logic         done;

  int vectors;
  int miscompares;
  logic seen_done;

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .ain  (ain),
    .bin  (bin),
    .out  (out),
    .c    (c),
    .z    (z),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; returns #1 after that edge.
  task automatic go(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    ain   = a;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    ain   = '0;
    bin   = '0;

    // Asynchronous reset between clock edges
    #7 rst = 1'b1;
    #1;
    chk("rst_out",  8'(out),  8'h0);
    chk("rst_c",    8'(c),    8'h0);
    chk("rst_z",    8'(z),    8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    @(negedge clk);
    rst = 1'b0;

    go(3'b000, 4'hF, 4'hF);
    chk("add_out",  8'(out),  8'hE);
    chk("add_c",    8'(c),    8'h1);
    chk("add_z",    8'(z),    8'h0);
    chk("add_done", 8'(done), 8'h1);

    go(3'b001, 4'h1, 4'h0);
    chk("adc_out",  8'(out),  8'h2);
    chk("adc_c",    8'(c),    8'h0);
    chk("adc_done", 8'(done), 8'h1);

    go(3'b011, 4'h0, 4'hF);
    chk("and_out", 8'(out), 8'h0);
    chk("and_z",   8'(z),   8'h1);
    chk("and_c",   8'(c),   8'h0);

    tick();
    chk("idle_done", 8'(done), 8'h0);
    chk("idle_out",  8'(out),  8'h0);

    go(3'b010, 4'h0, 4'h1);
    chk("sub_bor_out", 8'(out), 8'hF);
    chk("sub_bor_c",   8'(c),   8'h1);
    chk("sub_bor_z",   8'(z),   8'h0);

    go(3'b010, 4'h3, 4'h3);
    chk("sub_eq_out", 8'(out), 8'h0);
    chk("sub_eq_c",   8'(c),   8'h0);
    chk("sub_eq_z",   8'(z),   8'h1);

    go(3'b100, 4'h5, 4'hA);
    chk("or_out", 8'(out), 8'hF);
    chk("or_c",   8'(c),   8'h0);

    go(3'b101, 4'h6, 4'h3);
    chk("xor_out", 8'(out), 8'h5);

    go(3'b010, 4'h0, 4'h1);
    go(3'b111, 4'h8, 4'h5);
    chk("rlc_out", 8'(out), 8'h1);
    chk("rlc_c",   8'(c),   8'h1);
    chk("rlc_z",   8'(z),   8'h0);

    // MUL 3*5 with an ADD request held during busy
    go(3'b110, 4'h3, 4'h5);
    chk("mul1_busy_c1", 8'(busy), 8'h1);
    chk("mul1_done_c1", 8'(done), 8'h0);
    chk("mul1_hold",    8'(out),  8'h1);
    start = 1'b1;
    op    = 3'b000;
    ain   = 4'h1;
    bin   = 4'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mul1_busy", 8'(busy), 8'h1);
      chk("mul1_nodone", 8'(done), 8'h0);
    end
    start = 1'b0;
    tick();
    chk("mul1_busy_end", 8'(busy), 8'h0);
    chk("mul1_done",     8'(done), 8'h1);
    chk("mul1_out",      8'(out),  8'hF);
    chk("mul1_c",        8'(c),    8'h0);
    chk("mul1_z",        8'(z),    8'h0);
    tick();
    chk("mul1_single_done", 8'(done), 8'h0);
    chk("mul1_ignored",     8'(out),  8'hF);

    // MUL 15*15 then an ADD accepted in the done cycle
    go(3'b110, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mul2_busy", 8'(busy), 8'h1);
    end
    tick();
    chk("mul2_done", 8'(done), 8'h1);
    chk("mul2_out",  8'(out),  8'h1);
    chk("mul2_c",    8'(c),    8'h1);
    start = 1'b1;
    op    = 3'b000;
    ain   = 4'h1;
    bin   = 4'h1;
    tick();
    start = 1'b0;
    chk("post_mul_add_out",  8'(out),  8'h2);
    chk("post_mul_add_c",    8'(c),    8'h0);
    chk("post_mul_add_done", 8'(done), 8'h1);

    // Reset during multiply, in cycle N+2
    go(3'b110, 4'h7, 4'h7);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_out",  8'(out),  8'h0);
    chk("abort_c",    8'(c),    8'h0);
    chk("abort_z",    8'(z),    8'h0);
    chk("abort_busy", 8'(busy), 8'h0);
    chk("abort_done", 8'(done), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_done = seen_done | done;
    end
    chk("abort_no_done", 8'(seen_done), 8'h0);

    go(3'b110, 4'h2, 4'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mul3_busy", 8'(busy), 8'h1);
    end
    tick();
    chk("mul3_done", 8'(done), 8'h1);
    chk("mul3_busy_end", 8'(busy), 8'h0);
    chk("mul3_out",  8'(out),  8'h6);
    chk("mul3_c",    8'(c),    8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
